// File: rtl/lz77_pkg.sv
// rtl/lz77_pkg.sv - shared LZ77 widths, end-of-stream char and FSM encoding (encoder and decoder)
package lz77_pkg;

  localparam int SEARCH_DEPTH = 9;
  localparam int OFFSET_W     = 4;
  localparam int LEN_W        = 3;
  localparam int CHAR_W       = 8;

  localparam logic [CHAR_W-1:0] EOS_CHAR = 8'h24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COPY = 2'd1;
  localparam logic [1:0] ST_LIT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [OFFSET_W-1:0] offset;
    logic [LEN_W-1:0]    match_len;
    logic [CHAR_W-1:0]   char_nxt;
  } lz77_triple_t;

  // Count of valid history entries; stops at the window depth.
  function automatic logic [OFFSET_W-1:0] fill_next(input logic [OFFSET_W-1:0] fill);
    if (fill >= OFFSET_W'(SEARCH_DEPTH))
      return fill;
    return fill + 1'b1;
  endfunction

endpackage

// File: rtl/lz77_hist_buf.sv
// rtl/lz77_hist_buf.sv - LZ77 search history: shift register, entry 0 newest, indexed read
module lz77_hist_buf
  import lz77_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic [CHAR_W-1:0]   shift_data,
  input  logic [OFFSET_W-1:0] rd_idx,
  output logic [CHAR_W-1:0]   rd_data
);

  logic [CHAR_W-1:0] hist [SEARCH_DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SEARCH_DEPTH; i++)
        hist[i] <= '0;
    end else if (shift_en) begin
      hist[0] <= shift_data;
      for (int i = 1; i < SEARCH_DEPTH; i++)
        hist[i] <= hist[i-1];
    end
  end

  // Offsets beyond the window read as zero rather than aliasing.
  always_comb begin
    rd_data = '0;
    if (rd_idx < OFFSET_W'(SEARCH_DEPTH))
      rd_data = hist[rd_idx];
  end

endmodule

// File: rtl/lz77_decoder.sv
// rtl/lz77_decoder.sv - LZ77 (offset,len,char) triple decoder; LZ77_DEC_CHECK_EN adds sticky err output
module lz77_decoder
  import lz77_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                code_valid,
  output logic                code_ready,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [LEN_W-1:0]    match_len,
  input  logic [CHAR_W-1:0]   char_nxt,
  output logic                out_valid,
  output logic [CHAR_W-1:0]   out_char,
  output logic                finish
`ifdef LZ77_DEC_CHECK_EN
  ,
  output logic                err
`endif
);

  logic [1:0]         state;
  lz77_triple_t       cur;
  logic [LEN_W-1:0]   remaining;
  logic               accept;
  logic               shift_en;
  logic [CHAR_W-1:0]  hist_rd;
  logic [CHAR_W-1:0]  emit_char;

  assign code_ready = (state == ST_IDLE);
  assign accept     = code_valid && code_ready;

  // Each emitted char enters the history on the same edge it is registered out,
  // so overlapping copies see their own output on the next cycle.
  assign shift_en  = (state == ST_COPY) || (state == ST_LIT);
  assign emit_char = (state == ST_COPY) ? hist_rd : cur.char_nxt;

  lz77_hist_buf u_hist (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (shift_en),
    .shift_data (emit_char),
    .rd_idx     (cur.offset),
    .rd_data    (hist_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cur       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_char  <= '0;
      finish    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur       <= '{offset: offset, match_len: match_len, char_nxt: char_nxt};
            remaining <= match_len;
            state     <= (match_len != '0) ? ST_COPY : ST_LIT;
          end
        end
        ST_COPY: begin
          out_valid <= 1'b1;
          out_char  <= emit_char;
          remaining <= remaining - 1'b1;
          if (remaining == LEN_W'(1))
            state <= ST_LIT;
        end
        ST_LIT: begin
          out_valid <= 1'b1;
          out_char  <= emit_char;
          state     <= (cur.char_nxt == EOS_CHAR) ? ST_DONE : ST_IDLE;
        end
        ST_DONE: begin
          finish <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LZ77_DEC_CHECK_EN
  logic [OFFSET_W-1:0] fill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill <= '0;
      err  <= 1'b0;
    end else begin
      if (shift_en)
        fill <= fill_next(fill);
      if (accept && (match_len != '0) &&
          ((offset >= fill) || (offset > OFFSET_W'(SEARCH_DEPTH - 1))))
        err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// tb/tb_lz77_decoder.sv - scoreboard bench for lz77_decoder (LZ77_DEC_CHECK_EN selects err checks)
module tb_lz77_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [3:0] offset = '0;
  logic [2:0] match_len = '0;
  logic [7:0] char_nxt = '0;
  logic       out_valid;
  logic [7:0] out_char;
  logic       finish;
`ifdef LZ77_DEC_CHECK_EN
  logic       err;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];

  lz77_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .offset     (offset),
    .match_len  (match_len),
    .char_nxt   (char_nxt),
    .out_valid  (out_valid),
    .out_char   (out_char),
    .finish     (finish)
`ifdef LZ77_DEC_CHECK_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got %0h want none", out_char);
      end else begin
        e = exp_q.pop_front();
        check("out_char", {24'h0, out_char}, {24'h0, e});
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [2:0] l, input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    offset = o; match_len = l; char_nxt = c; code_valid = 1'b1;
    while (!code_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'h0, code_ready}, 32'd1);
    @(posedge clk);
    #1 code_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !(code_ready || finish)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b0; code_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_finish", {31'h0, finish}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {31'h0, code_ready}, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] ch;
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'h0, out_valid}, 32'd0);
    check("reset_out_char", {24'h0, out_char}, 32'd0);
    check("reset_finish", {31'h0, finish}, 32'd0);
    check("reset_ready", {31'h0, code_ready}, 32'd1);
`ifdef LZ77_DEC_CHECK_EN
    check("reset_err", {31'h0, err}, 32'd0);
`endif
    reset = 1'b1;

    // Literals and end of stream
    exp_q.push_back("a"); exp_q.push_back("b"); exp_q.push_back("$");
    send(4'd0, 3'd0, "a");
    send(4'd0, 3'd0, "b");
    send(4'd0, 3'd0, "$");
    @(negedge clk);
    @(negedge clk);
    check("eos_pulse", {31'h0, out_valid}, 32'd1);
    check("eos_finish_early", {31'h0, finish}, 32'd0);
    @(negedge clk);
    check("eos_finish", {31'h0, finish}, 32'd1);
    check("eos_no_pulse", {31'h0, out_valid}, 32'd0);
    offset = 4'd0; match_len = 3'd0; char_nxt = "k"; code_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("done_ready", {31'h0, code_ready}, 32'd0);
      check("done_finish_held", {31'h0, finish}, 32'd1);
    end
    code_valid = 1'b0;
    check("lit_queue", exp_q.size(), 32'd0);
    do_reset();

    // Overlapping copy: offset 0 length 5 repeats the previous char
    exp_q.push_back("a");
    send(4'd0, 3'd0, "a");
    for (int i = 0; i < 5; i++) exp_q.push_back("a");
    exp_q.push_back("c");
    send(4'd0, 3'd5, "c");
    @(negedge clk);
    check("copy_latency", {31'h0, out_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("overlap_run", {31'h0, out_valid}, 32'd1);
    end
    @(negedge clk);
    check("overlap_end", {31'h0, out_valid}, 32'd0);
    drain("overlap_drain");
    do_reset();

    // Full window depth: offset 8 reaches the oldest char
    for (int d = 0; d < 9; d++) begin
      ch = 8'h31 + 8'(d);
      exp_q.push_back(ch);
      send(4'd0, 3'd0, ch);
    end
    exp_q.push_back("1"); exp_q.push_back("2"); exp_q.push_back("3"); exp_q.push_back("x");
    send(4'd8, 3'd3, "x");
    drain("depth_drain");
    do_reset();

    // Backpressure: fields change while busy and must be ignored
    exp_q.push_back("p");
    send(4'd0, 3'd0, "p");
    exp_q.push_back("p"); exp_q.push_back("p"); exp_q.push_back("p"); exp_q.push_back("r");
    exp_q.push_back("p"); exp_q.push_back("m");
    send(4'd0, 3'd3, "r");
    code_valid = 1'b1;
    offset = 4'd5; match_len = 3'd7; char_nxt = "#";
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_ready", {31'h0, code_ready}, 32'd0);
      if (i == 3) begin
        offset = 4'd1; match_len = 3'd1; char_nxt = "m";
      end else begin
        offset = 4'(i + 2); match_len = 3'(6 - i); char_nxt = 8'h40 + 8'(i);
      end
    end
    @(negedge clk);
    check("busy_release_ready", {31'h0, code_ready}, 32'd1);
    @(posedge clk);
    #1 code_valid = 1'b0;
    drain("busy_drain");

    // Reset in the middle of a copy
    do_reset();
    exp_q.push_back("z");
    send(4'd0, 3'd0, "z");
    exp_q.push_back("z"); exp_q.push_back("z");
    send(4'd0, 3'd7, "z");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    check("midrst_finish", {31'h0, finish}, 32'd0);
    reset = 1'b1;
    check("midrst_ready", {31'h0, code_ready}, 32'd1);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back("k");
    send(4'd0, 3'd2, "k");
    drain("midrst_hist_cleared");

    // Offset beyond decoded history
    do_reset();
`ifdef LZ77_DEC_CHECK_EN
    check("chk_err_idle", {31'h0, err}, 32'd0);
`endif
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back("q");
    send(4'd3, 3'd2, "q");
`ifdef LZ77_DEC_CHECK_EN
    @(negedge clk);
    check("chk_err_set", {31'h0, err}, 32'd1);
`endif
    drain("chk_drain");
    exp_q.push_back("q");
    send(4'd0, 3'd0, "q");
    drain("chk_drain2");
`ifdef LZ77_DEC_CHECK_EN
    check("chk_err_sticky", {31'h0, err}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
